// File: rtl/credit_sink_pkg.sv
// credit_pkg: types and defaults shared by the credit sink and the crossbar.
//   credit_t   - credit counter type, sized for the largest supported credit pool.
//   state_e    - credit-return phase: INIT until the first credit leaves, then RUN.
//   MaxCredits - upper bound on the credit pool, shared default for all counters.
package credit_pkg;

  localparam int unsigned MaxCredits = 15;

  typedef logic [$clog2(MaxCredits):0] credit_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/credit_sink_if.sv
// credit_sink_if: bundle between the crossbar/downstream side and one credit sink.
//   push side : valid_i, data_i, ini_addr_i (in to sink), credit_o (out of sink)
//   pop side  : valid_o, data_o, ini_addr_o (out of sink), ready_i (in to sink)
//   status    : usage_o (FIFO occupancy), overflow_o (sticky protocol violation)
// Modport slave is the sink's view; modport master is the environment's view.
interface credit_sink_if #(
  parameter int unsigned NumIn      = 4,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned MaxCredits = credit_pkg::MaxCredits
);

  localparam int unsigned IniW = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned CntW = $clog2(MaxCredits) + 1;

  logic                 valid_i;
  logic [DataWidth-1:0] data_i;
  logic [IniW-1:0]      ini_addr_i;
  logic                 credit_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [DataWidth-1:0] data_o;
  logic [IniW-1:0]      ini_addr_o;
  logic [CntW-1:0]      usage_o;
  logic                 overflow_o;

  modport slave (
    input  valid_i, data_i, ini_addr_i, ready_i,
    output credit_o, valid_o, data_o, ini_addr_o, usage_o, overflow_o
  );

  modport master (
    output valid_i, data_i, ini_addr_i, ready_i,
    input  credit_o, valid_o, data_o, ini_addr_o, usage_o, overflow_o
  );

endinterface

// File: rtl/credit_sink_credit_return_ctrl.sv
// credit_return_ctrl: credit bookkeeping for one credit sink.
//   clk_i, rst_ni - clock, synchronous active-low reset
//   pop_i         - one entry consumed downstream this cycle (owes one credit)
//   credit_o      - registered credit pulse, at most one per cycle
// pending_q holds credits owed to the sender. It reloads to NumCredits on reset,
// which is how the initial credit pool is handed out one per cycle.
module credit_return_ctrl #(
  parameter int unsigned NumCredits = 2,
  parameter int unsigned MaxCredits = credit_pkg::MaxCredits
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pop_i,
  output logic credit_o
);

  import credit_pkg::*;

  localparam int unsigned CntW = $clog2(MaxCredits) + 1;
  typedef logic [CntW-1:0] cnt_t;

  cnt_t   pending_q, pending_d;
  logic   credit_q;
  logic   issue;
  state_e state_q, state_d;

  assign issue = (pending_q != '0);

  always_comb begin
    pending_d = pending_q;
    state_d   = state_q;
    // A pop and an issue in the same cycle cancel, so no credit is ever lost.
    pending_d = pending_q + cnt_t'(pop_i) - cnt_t'(issue);
    if (state_q == INIT && credit_q) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= cnt_t'(NumCredits);
      credit_q  <= 1'b0;
      state_q   <= INIT;
    end else begin
      pending_q <= pending_d;
      credit_q  <= issue;
      state_q   <= state_d;
    end
  end

  assign credit_o = credit_q;

`ifndef SYNTHESIS
  // Until the first credit has gone out, something must still be owed.
  init_owes_credit : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == INIT) |-> (issue || credit_q));
`endif

endmodule

// File: rtl/fifo_v3.sv
// fifo_v3: small show-ahead FIFO.
//   clk_i, rst_ni   - clock, synchronous active-low reset (pointers/count only)
//   push_i, data_i  - write request and payload; ignored when full without a pop
//   pop_i           - consume head entry
//   data_o          - head entry (or data_i when FALL_THROUGH and empty)
//   full_o, empty_o - occupancy flags, derived from stored state only
//   usage_o         - number of stored entries
// With FALL_THROUGH, a push and pop on an empty FIFO pass straight through
// without being stored. empty_o deliberately ignores that path so callers can
// build their own valid signal without a combinational loop through this block.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 2,
  localparam int unsigned AddrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AddrW:0]        usage_o
);

  typedef logic [AddrW-1:0] ptr_t;
  typedef logic [AddrW:0]   cnt_t;

  // Shallow array with asynchronous read: the head must be visible in the
  // same cycle it is popped, so this maps to registers / distributed RAM.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  ptr_t wr_ptr_q, rd_ptr_q;
  cnt_t cnt_q;
  logic pass_through, do_write, do_read;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == cnt_t'(DEPTH));
  assign usage_o = cnt_q;

  assign pass_through = FALL_THROUGH && empty_o && push_i && pop_i;
  assign do_write     = push_i && !pass_through && (!full_o || pop_i);
  assign do_read      = pop_i && !empty_o;

  assign data_o = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_write) begin
        wr_ptr_q <= (wr_ptr_q == ptr_t'(DEPTH - 1)) ? '0 : wr_ptr_q + ptr_t'(1);
      end
      if (do_read) begin
        rd_ptr_q <= (rd_ptr_q == ptr_t'(DEPTH - 1)) ? '0 : rd_ptr_q + ptr_t'(1);
      end
      cnt_q <= cnt_q + cnt_t'(do_write) - cnt_t'(do_read);
    end
  end

endmodule

// File: rtl/credit_sink.sv
// credit_sink: target-side endpoint of the credit-based simplex crossbar.
//   clk_i, rst_ni - clock, synchronous active-low reset
//   bus (slave)   - push from crossbar (valid_i/data_i/ini_addr_i), credit_o back,
//                   downstream valid_o/ready_i/data_o/ini_addr_o, usage_o, overflow_o
// Pushes carry no backpressure; the sender only pushes while holding a credit,
// so the NumCredits-deep FIFO cannot legally overflow. An illegal push into a
// full FIFO (without a simultaneous pop) is dropped and latches overflow_o.
// Build option CREDIT_SINK_BYPASS_EN: an empty FIFO forwards the push to the
// downstream port in the same cycle; otherwise push-to-valid latency is one cycle.
module credit_sink #(
  parameter int unsigned NumIn      = 4,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned NumCredits = 2,
  parameter int unsigned MaxCredits = credit_pkg::MaxCredits
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  credit_sink_if.slave  bus
);

  import credit_pkg::*;

  localparam int unsigned IniW      = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned CntW      = $clog2(MaxCredits) + 1;
  localparam int unsigned EntryW    = DataWidth + IniW;
  localparam int unsigned FifoAddrW = (NumCredits > 1) ? $clog2(NumCredits) : 1;

`ifdef CREDIT_SINK_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef logic [CntW-1:0] cnt_t;

  logic                fifo_full, fifo_empty;
  logic [FifoAddrW:0]  fifo_usage;
  logic [EntryW-1:0]   fifo_wdata, fifo_rdata;
  logic                head_valid, push, pop;
  logic                overflow_q;

  assign fifo_wdata = {bus.data_i, bus.ini_addr_i};

`ifdef CREDIT_SINK_BYPASS_EN
  assign head_valid = !fifo_empty || bus.valid_i;
`else
  assign head_valid = !fifo_empty;
`endif

  assign pop  = head_valid && bus.ready_i;
  // Full is only escapable when the head leaves in the same cycle.
  assign push = bus.valid_i && (!fifo_full || pop);

  fifo_v3 #(
    .FALL_THROUGH (Bypass),
    .DATA_WIDTH   (EntryW),
    .DEPTH        (NumCredits)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
    end else if (bus.valid_i && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  credit_return_ctrl #(
    .NumCredits (NumCredits),
    .MaxCredits (MaxCredits)
  ) u_credit_return_ctrl (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .pop_i    (pop),
    .credit_o (bus.credit_o)
  );

  assign bus.valid_o    = head_valid;
  assign bus.data_o     = fifo_rdata[EntryW-1:IniW];
  assign bus.ini_addr_o = fifo_rdata[IniW-1:0];
  assign bus.usage_o    = cnt_t'(fifo_usage);
  assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_credit_sink.sv
// tb_credit_sink: directed, table-driven bench for credit_sink (NumCredits=2,
// DataWidth=32, NumIn=4). Inputs change 1 ns after the rising edge; outputs are
// checked on the falling edge of the same cycle.
module tb_credit_sink;

  logic clk = 1'b0;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  credit_sink_if #(.NumIn(4), .DataWidth(32), .MaxCredits(15)) bus ();

  credit_sink #(
    .NumIn      (4),
    .DataWidth  (32),
    .NumCredits (2),
    .MaxCredits (15)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [31:0] data;
    logic [1:0]  ini;
    logic        rdy;
    logic        e_credit;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_ini;
    logic [4:0]  e_usage;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(input logic rst_n, input logic vld, input logic [31:0] data,
                              input logic [1:0] ini, input logic rdy, input logic e_credit,
                              input logic e_valid, input logic [31:0] e_data,
                              input logic [1:0] e_ini, input logic [4:0] e_usage,
                              input logic e_ovf);
    vec_t v;
    v.rst_n = rst_n; v.vld = vld; v.data = data; v.ini = ini; v.rdy = rdy;
    v.e_credit = e_credit; v.e_valid = e_valid; v.e_data = e_data;
    v.e_ini = e_ini; v.e_usage = e_usage; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic vld, input logic [31:0] data,
                       input logic [1:0] ini, input logic rdy);
    rst_ni         = rst_n;
    bus.valid_i    = vld;
    bus.data_i     = data;
    bus.ini_addr_i = ini;
    bus.ready_i    = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Row = one cycle after the reset edge (cycle 0 first).
    //            rst vld data          ini rdy  cred val e_data        eini use ovf
    vecs[0]  = mk(1, 0, 32'h0,        0, 0,   0, 0, 32'h0,        0, 0, 0);
    vecs[1]  = mk(1, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 0, 0);
    vecs[2]  = mk(1, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 0, 0);
    vecs[3]  = mk(1, 1, 32'hDEADBEEF, 3, 0,   0, 0, 32'h0,        0, 0, 0);
    vecs[4]  = mk(1, 0, 32'h0,        0, 0,   0, 1, 32'hDEADBEEF, 3, 1, 0);
    vecs[5]  = mk(1, 0, 32'h0,        0, 0,   0, 1, 32'hDEADBEEF, 3, 1, 0);
    vecs[6]  = mk(1, 0, 32'h0,        0, 1,   0, 1, 32'hDEADBEEF, 3, 1, 0);
    vecs[7]  = mk(1, 0, 32'h0,        0, 1,   0, 0, 32'h0,        0, 0, 0);
    vecs[8]  = mk(1, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 0, 0);
    vecs[9]  = mk(1, 1, 32'h11111111, 0, 0,   0, 0, 32'h0,        0, 0, 0);
    vecs[10] = mk(1, 1, 32'h22222222, 1, 0,   0, 1, 32'h11111111, 0, 1, 0);
    // full: push and pop together is legal
    vecs[11] = mk(1, 1, 32'h33333333, 2, 1,   0, 1, 32'h11111111, 0, 2, 0);
    vecs[12] = mk(1, 0, 32'h0,        0, 0,   0, 1, 32'h22222222, 1, 2, 0);
    vecs[13] = mk(1, 0, 32'h0,        0, 0,   1, 1, 32'h22222222, 1, 2, 0);
    // full, push without pop: dropped, overflow sticks
    vecs[14] = mk(1, 1, 32'h44444444, 3, 0,   0, 1, 32'h22222222, 1, 2, 0);
    vecs[15] = mk(1, 0, 32'h0,        0, 1,   0, 1, 32'h22222222, 1, 2, 1);
    vecs[16] = mk(1, 0, 32'h0,        0, 1,   0, 1, 32'h33333333, 2, 1, 1);
    vecs[17] = mk(1, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 0, 1);
    vecs[18] = mk(1, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 0, 1);
    vecs[19] = mk(1, 1, 32'h55555555, 0, 0,   0, 0, 32'h0,        0, 0, 1);
    vecs[20] = mk(1, 1, 32'h66666666, 1, 0,   0, 1, 32'h55555555, 0, 1, 1);
    // reset while full and overflowed
    vecs[21] = mk(0, 0, 32'h0,        0, 0,   0, 1, 32'h55555555, 0, 2, 1);
    vecs[22] = mk(1, 0, 32'h0,        0, 0,   0, 0, 32'h0,        0, 0, 0);
    vecs[23] = mk(1, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 0, 0);
    vecs[24] = mk(1, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 0, 0);
    vecs[25] = mk(1, 0, 32'h0,        0, 0,   0, 0, 32'h0,        0, 0, 0);

    drive(0, 0, 32'h0, 0, 0);
    next_cycle();
    next_cycle();

`ifndef CREDIT_SINK_BYPASS_EN
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].rst_n, vecs[i].vld, vecs[i].data, vecs[i].ini, vecs[i].rdy);
      sample();
      $display("row %0d: vld=%0b rdy=%0b -> credit=%0b valid=%0b data=0x%0h ini=%0d usage=%0d ovf=%0b",
               i, vecs[i].vld, vecs[i].rdy, bus.credit_o, bus.valid_o, bus.data_o,
               bus.ini_addr_o, bus.usage_o, bus.overflow_o);
      check($sformatf("row%0d credit_o", i), 32'(bus.credit_o), 32'(vecs[i].e_credit));
      check($sformatf("row%0d valid_o", i), 32'(bus.valid_o), 32'(vecs[i].e_valid));
      check($sformatf("row%0d usage_o", i), 32'(bus.usage_o), 32'(vecs[i].e_usage));
      check($sformatf("row%0d overflow_o", i), 32'(bus.overflow_o), 32'(vecs[i].e_ovf));
      if (vecs[i].e_valid) begin
        check($sformatf("row%0d data_o", i), bus.data_o, vecs[i].e_data);
        check($sformatf("row%0d ini_addr_o", i), 32'(bus.ini_addr_o), 32'(vecs[i].e_ini));
      end
      next_cycle();
    end
`endif

    // Pop inside the initial credit window: the returned credit extends the
    // run of credit pulses to three consecutive cycles (cycles 1..3).
    drive(0, 0, 32'h0, 0, 0);
    next_cycle();
    drive(1, 1, 32'hA5A5A5A5, 2, 0);
    sample();
    $display("window c0: credit=%0b", bus.credit_o);
    check("window c0 credit_o", 32'(bus.credit_o), 32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 0, 1);
    sample();
    $display("window c1: credit=%0b valid=%0b data=0x%0h", bus.credit_o, bus.valid_o, bus.data_o);
    check("window c1 credit_o", 32'(bus.credit_o), 32'd1);
    check("window c1 valid_o", 32'(bus.valid_o), 32'd1);
    check("window c1 data_o", bus.data_o, 32'hA5A5A5A5);
    next_cycle();
    drive(1, 0, 32'h0, 0, 0);
    sample();
    $display("window c2: credit=%0b usage=%0d", bus.credit_o, bus.usage_o);
    check("window c2 credit_o", 32'(bus.credit_o), 32'd1);
    check("window c2 usage_o", 32'(bus.usage_o), 32'd0);
    next_cycle();
    sample();
    $display("window c3: credit=%0b", bus.credit_o);
    check("window c3 credit_o", 32'(bus.credit_o), 32'd1);
    next_cycle();
    sample();
    $display("window c4: credit=%0b", bus.credit_o);
    check("window c4 credit_o", 32'(bus.credit_o), 32'd0);

`ifdef CREDIT_SINK_BYPASS_EN
    // Empty FIFO, push with ready: forwarded in the same cycle, never stored.
    next_cycle();
    drive(1, 1, 32'h1, 0, 1);
    sample();
    $display("bypass c5: valid=%0b data=0x%0h usage=%0d", bus.valid_o, bus.data_o, bus.usage_o);
    check("bypass valid_o", 32'(bus.valid_o), 32'd1);
    check("bypass data_o", bus.data_o, 32'h1);
    check("bypass usage_o", 32'(bus.usage_o), 32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 0, 0);
    sample();
    $display("bypass c6: valid=%0b usage=%0d credit=%0b", bus.valid_o, bus.usage_o, bus.credit_o);
    check("bypass c6 valid_o", 32'(bus.valid_o), 32'd0);
    check("bypass c6 usage_o", 32'(bus.usage_o), 32'd0);
    check("bypass c6 credit_o", 32'(bus.credit_o), 32'd0);
    next_cycle();
    sample();
    $display("bypass c7: credit=%0b", bus.credit_o);
    check("bypass c7 credit_o", 32'(bus.credit_o), 32'd1);
    next_cycle();
    sample();
    $display("bypass c8: credit=%0b", bus.credit_o);
    check("bypass c8 credit_o", 32'(bus.credit_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
